// File: rtl/ex_branch_if.sv
// Issue, flush and result bus between branch reservation station, branch unit and ROB.
// Signal names follow the unit's port list; master drives issue/kill/ack, slave drives results.
interface ex_branch_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int TAG_W  = 6,
    parameter int OP_W   = 4
);
    logic              o_ready;
    logic              i_is_vld;
    logic              i_is_jal;
    logic              i_is_jalr;
    logic [OP_W-1:0]   i_alu_op_sel;
    logic [DATA_W-1:0] i_rs1_srcopr;
    logic [DATA_W-1:0] i_rs2_srcopr;
    logic [PC_W-1:0]   i_pc;
    logic [DATA_W-1:0] i_imm;
    logic [PC_W-1:0]   i_pred_jmpaddr;
    logic [TAG_W-1:0]  i_rrftag;
    logic              i_kill;
    logic              i_wb_ack;
    logic              o_fin;
    logic              o_exfin_jal_jalr;
    logic [TAG_W-1:0]  o_ex_jal_jalr_rrftag;
    logic [DATA_W-1:0] o_exfin_jal_jalr_res;
    logic              o_br_taken;
    logic [PC_W-1:0]   o_br_target;
    logic              o_br_mispred;

    modport master (
        input  o_ready, o_fin, o_exfin_jal_jalr, o_ex_jal_jalr_rrftag,
               o_exfin_jal_jalr_res, o_br_taken, o_br_target, o_br_mispred,
        output i_is_vld, i_is_jal, i_is_jalr, i_alu_op_sel, i_rs1_srcopr,
               i_rs2_srcopr, i_pc, i_imm, i_pred_jmpaddr, i_rrftag, i_kill, i_wb_ack
    );

    modport slave (
        output o_ready, o_fin, o_exfin_jal_jalr, o_ex_jal_jalr_rrftag,
               o_exfin_jal_jalr_res, o_br_taken, o_br_target, o_br_mispred,
        input  i_is_vld, i_is_jal, i_is_jalr, i_alu_op_sel, i_rs1_srcopr,
               i_rs2_srcopr, i_pc, i_imm, i_pred_jmpaddr, i_rrftag, i_kill, i_wb_ack
    );
endinterface

// File: rtl/ex_branch.sv
// Branch execution unit: E1 operand latch, E2 result latch; result 2 edges after issue.
// E2 holds until i_wb_ack; o_ready drops only when both stages are full and E2 is unacked.
module ex_branch #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int TAG_W  = 6,
    parameter int OP_W   = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    ex_branch_if.slave     bif
);
    logic              e1_vld_q, e1_jal_q, e1_jalr_q;
    logic [OP_W-1:0]   e1_op_q;
    logic [DATA_W-1:0] e1_rs1_q, e1_rs2_q, e1_imm_q;
    logic [PC_W-1:0]   e1_pc_q, e1_pred_q;
    logic [TAG_W-1:0]  e1_tag_q;

    logic              e2_vld_q, e2_jj_q, e2_taken_q, e2_mispred_q;
    logic [TAG_W-1:0]  e2_tag_q;
    logic [DATA_W-1:0] e2_res_q;
    logic [PC_W-1:0]   e2_target_q;

    logic              adv2, accept;
    logic              cond_taken, taken_d;
    logic [PC_W-1:0]   link_pc, pc_imm, jalr_tgt, target_d;
    logic [DATA_W-1:0] jalr_sum;

    assign adv2        = e1_vld_q && (!e2_vld_q || bif.i_wb_ack);
    assign bif.o_ready = !e1_vld_q || adv2;
    assign accept      = bif.i_is_vld && bif.o_ready && !bif.i_kill;

    assign link_pc  = e1_pc_q + PC_W'(4);
    assign pc_imm   = e1_pc_q + PC_W'(e1_imm_q);
    assign jalr_sum = e1_rs1_q + e1_imm_q;
    assign jalr_tgt = PC_W'(jalr_sum) & ~PC_W'(1);

    always_comb begin
        cond_taken = 1'b0;
        case (e1_op_q)
            OP_W'(0): cond_taken = (e1_rs1_q == e1_rs2_q);
            OP_W'(1): cond_taken = (e1_rs1_q != e1_rs2_q);
            OP_W'(2): cond_taken = ($signed(e1_rs1_q) <  $signed(e1_rs2_q));
            OP_W'(3): cond_taken = ($signed(e1_rs1_q) >= $signed(e1_rs2_q));
            OP_W'(4): cond_taken = (e1_rs1_q <  e1_rs2_q);
            OP_W'(5): cond_taken = (e1_rs1_q >= e1_rs2_q);
            default:  cond_taken = 1'b0;
        endcase
    end

    // JAL wins over JALR when both flags are set.
    always_comb begin
        taken_d  = 1'b1;
        target_d = pc_imm;
        if (!e1_jal_q && e1_jalr_q) begin
            target_d = jalr_tgt;
        end else if (!e1_jal_q) begin
            taken_d  = cond_taken;
            target_d = cond_taken ? pc_imm : link_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e1_vld_q  <= 1'b0;
            e1_jal_q  <= 1'b0;
            e1_jalr_q <= 1'b0;
            e1_op_q   <= '0;
            e1_rs1_q  <= '0;
            e1_rs2_q  <= '0;
            e1_imm_q  <= '0;
            e1_pc_q   <= '0;
            e1_pred_q <= '0;
            e1_tag_q  <= '0;
        end else if (bif.i_kill) begin
            e1_vld_q <= 1'b0;
        end else if (accept) begin
            e1_vld_q  <= 1'b1;
            e1_jal_q  <= bif.i_is_jal;
            e1_jalr_q <= bif.i_is_jalr;
            e1_op_q   <= bif.i_alu_op_sel;
            e1_rs1_q  <= bif.i_rs1_srcopr;
            e1_rs2_q  <= bif.i_rs2_srcopr;
            e1_imm_q  <= bif.i_imm;
            e1_pc_q   <= bif.i_pc;
            e1_pred_q <= bif.i_pred_jmpaddr;
            e1_tag_q  <= bif.i_rrftag;
        end else if (adv2) begin
            e1_vld_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e2_vld_q     <= 1'b0;
            e2_jj_q      <= 1'b0;
            e2_taken_q   <= 1'b0;
            e2_mispred_q <= 1'b0;
            e2_tag_q     <= '0;
            e2_res_q     <= '0;
            e2_target_q  <= '0;
        end else if (bif.i_kill) begin
            e2_vld_q <= 1'b0;
        end else if (adv2) begin
            e2_vld_q     <= 1'b1;
            e2_jj_q      <= e1_jal_q || e1_jalr_q;
            e2_taken_q   <= taken_d;
            e2_mispred_q <= (target_d != e1_pred_q);
            e2_tag_q     <= e1_tag_q;
            e2_res_q     <= DATA_W'(link_pc);
            e2_target_q  <= target_d;
        end else if (bif.i_wb_ack) begin
            e2_vld_q <= 1'b0;
        end
    end

    assign bif.o_fin                = e2_vld_q;
    assign bif.o_exfin_jal_jalr     = e2_vld_q && e2_jj_q;
    assign bif.o_ex_jal_jalr_rrftag = e2_tag_q;
    assign bif.o_exfin_jal_jalr_res = e2_res_q;
    assign bif.o_br_taken           = e2_taken_q;
    assign bif.o_br_target          = e2_target_q;
    assign bif.o_br_mispred         = e2_mispred_q;
endmodule

// File: tb/tb_ex_branch.sv
// Directed bench for ex_branch: vector table for single ops, hand sequences for pipelining, back-pressure and flush.
module tb_ex_branch;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ex_branch_if #(.DATA_W(32), .PC_W(32), .TAG_W(6), .OP_W(4)) bif ();
    ex_branch #(.DATA_W(32), .PC_W(32), .TAG_W(6), .OP_W(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bif   (bif)
    );

    typedef struct {
        logic        jal;
        logic        jalr;
        logic [3:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] pred;
        logic [5:0]  tag;
        logic        e_taken;
        logic [31:0] e_target;
        logic        e_mispred;
        logic        e_jj;
        logic [31:0] e_res;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive_op(input vec_t v);
        bif.i_is_vld       = 1'b1;
        bif.i_is_jal       = v.jal;
        bif.i_is_jalr      = v.jalr;
        bif.i_alu_op_sel   = v.op;
        bif.i_rs1_srcopr   = v.rs1;
        bif.i_rs2_srcopr   = v.rs2;
        bif.i_pc           = v.pc;
        bif.i_imm          = v.imm;
        bif.i_pred_jmpaddr = v.pred;
        bif.i_rrftag       = v.tag;
    endtask

    function automatic vec_t simple_op(input logic [5:0] tag, input logic [31:0] pc);
        vec_t v;
        v = '{1'b1, 1'b0, 4'd0, 32'd0, 32'd0, pc, 32'h10, pc + 32'h10, tag,
              1'b1, pc + 32'h10, 1'b0, 1'b1, pc + 32'd4};
        return v;
    endfunction

    initial begin
        vec_t v;
        //            jal  jalr op    rs1           rs2   pc            imm           pred          tag    tkn  target        misp jj   res
        vecs[0]  = '{1'b1, 1'b0, 4'd0, 32'h0,        32'h0, 32'h100,      32'h20,       32'h120,      6'd5,  1'b1, 32'h120,      1'b0, 1'b1, 32'h104};
        vecs[1]  = '{1'b0, 1'b1, 4'd0, 32'h2001,     32'h0, 32'h300,      32'h4,        32'h2000,     6'd6,  1'b1, 32'h2004,     1'b1, 1'b1, 32'h304};
        vecs[2]  = '{1'b0, 1'b0, 4'd2, 32'hFFFFFFFF, 32'h1, 32'h400,      32'h40,       32'h404,      6'd7,  1'b1, 32'h440,      1'b1, 1'b0, 32'h404};
        vecs[3]  = '{1'b0, 1'b0, 4'd4, 32'hFFFFFFFF, 32'h1, 32'h400,      32'h40,       32'h404,      6'd8,  1'b0, 32'h404,      1'b0, 1'b0, 32'h404};
        vecs[4]  = '{1'b0, 1'b0, 4'd0, 32'h7,        32'h7, 32'h500,      32'hFFFFFFF0, 32'h4F0,      6'd9,  1'b1, 32'h4F0,      1'b0, 1'b0, 32'h504};
        vecs[5]  = '{1'b0, 1'b0, 4'd1, 32'h7,        32'h7, 32'h500,      32'hFFFFFFF0, 32'h4F0,      6'd10, 1'b0, 32'h504,      1'b1, 1'b0, 32'h504};
        vecs[6]  = '{1'b0, 1'b0, 4'd3, 32'h80000000, 32'h0, 32'h600,      32'h8,        32'h604,      6'd11, 1'b0, 32'h604,      1'b0, 1'b0, 32'h604};
        vecs[7]  = '{1'b0, 1'b0, 4'd5, 32'h80000000, 32'h0, 32'h600,      32'h8,        32'h604,      6'd12, 1'b1, 32'h608,      1'b1, 1'b0, 32'h604};
        vecs[8]  = '{1'b0, 1'b0, 4'd6, 32'h0,        32'h0, 32'h700,      32'h10,       32'h710,      6'd13, 1'b0, 32'h704,      1'b1, 1'b0, 32'h704};
        vecs[9]  = '{1'b1, 1'b1, 4'd0, 32'h1,        32'h0, 32'h800,      32'h10,       32'h810,      6'd14, 1'b1, 32'h810,      1'b0, 1'b1, 32'h804};
        vecs[10] = '{1'b1, 1'b0, 4'd0, 32'h0,        32'h0, 32'hFFFFFFFC, 32'h8,        32'h0,        6'd15, 1'b1, 32'h4,        1'b1, 1'b1, 32'h0};

        bif.i_is_vld = 1'b0; bif.i_is_jal = 1'b0; bif.i_is_jalr = 1'b0;
        bif.i_alu_op_sel = '0; bif.i_rs1_srcopr = '0; bif.i_rs2_srcopr = '0;
        bif.i_pc = '0; bif.i_imm = '0; bif.i_pred_jmpaddr = '0; bif.i_rrftag = '0;
        bif.i_kill = 1'b0; bif.i_wb_ack = 1'b1;

        #12;
        chk("rst_ready",  bif.o_ready, 1);
        chk("rst_fin",    bif.o_fin, 0);
        chk("rst_jj",     bif.o_exfin_jal_jalr, 0);
        chk("rst_tag",    bif.o_ex_jal_jalr_rrftag, 0);
        chk("rst_res",    bif.o_exfin_jal_jalr_res, 0);
        chk("rst_taken",  bif.o_br_taken, 0);
        chk("rst_target", bif.o_br_target, 0);
        chk("rst_misp",   bif.o_br_mispred, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", bif.o_ready, 1);
        chk("idle_fin",   bif.o_fin, 0);

        // Single ops with ack held high: result visible two edges after issue.
        for (int i = 0; i < 11; i++) begin
            drive_op(vecs[i]);
            @(negedge clk);
            bif.i_is_vld = 1'b0;
            chk("e1_no_fin", bif.o_fin, 0);
            @(negedge clk);
            chk("fin",     bif.o_fin, 1);
            chk("taken",   bif.o_br_taken, vecs[i].e_taken);
            chk("target",  bif.o_br_target, vecs[i].e_target);
            chk("mispred", bif.o_br_mispred, vecs[i].e_mispred);
            chk("jj",      bif.o_exfin_jal_jalr, vecs[i].e_jj);
            chk("res",     bif.o_exfin_jal_jalr_res, vecs[i].e_res);
            chk("tag",     bif.o_ex_jal_jalr_rrftag, vecs[i].tag);
            @(negedge clk);
            chk("drained", bif.o_fin, 0);
        end

        // Back-to-back issue with continuous ack: one result per cycle, in order.
        for (int i = 0; i < 5; i++) begin
            if (i >= 2) begin
                chk("thru_fin", bif.o_fin, 1);
                chk("thru_tag", bif.o_ex_jal_jalr_rrftag, 6'd20 + 6'(i - 2));
            end
            chk("thru_ready", bif.o_ready, 1);
            if (i < 3) drive_op(simple_op(6'd20 + 6'(i), 32'h1000 + 32'(i) * 32'h100));
            else       bif.i_is_vld = 1'b0;
            @(negedge clk);
        end
        chk("thru_end_tag", bif.o_ex_jal_jalr_rrftag, 6'd22);
        @(negedge clk);
        chk("thru_empty", bif.o_fin, 0);

        // Back-pressure: ack low, three issues; third must be ignored.
        bif.i_wb_ack = 1'b0;
        drive_op(simple_op(6'd1, 32'h2000));
        @(negedge clk);
        chk("bp_ready1", bif.o_ready, 1);
        drive_op(simple_op(6'd2, 32'h3000));
        @(negedge clk);
        chk("bp_ready0", bif.o_ready, 0);
        chk("bp_fin",    bif.o_fin, 1);
        chk("bp_tagA",   bif.o_ex_jal_jalr_rrftag, 1);
        drive_op(simple_op(6'd3, 32'h4000));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_ready",  bif.o_ready, 0);
            chk("bp_hold_fin",    bif.o_fin, 1);
            chk("bp_hold_tag",    bif.o_ex_jal_jalr_rrftag, 1);
            chk("bp_hold_target", bif.o_br_target, 32'h2010);
        end
        bif.i_is_vld = 1'b0;
        bif.i_wb_ack = 1'b1;
        @(negedge clk);
        chk("bp_drain_fin",    bif.o_fin, 1);
        chk("bp_drain_tagB",   bif.o_ex_jal_jalr_rrftag, 2);
        chk("bp_drain_target", bif.o_br_target, 32'h3010);
        chk("bp_drain_ready",  bif.o_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_no_C", bif.o_fin, 0);
        end

        // Flush with both stages full and a concurrent issue.
        bif.i_wb_ack = 1'b0;
        drive_op(simple_op(6'd30, 32'h5000));
        @(negedge clk);
        drive_op(simple_op(6'd31, 32'h6000));
        @(negedge clk);
        chk("fl_full_ready", bif.o_ready, 0);
        chk("fl_full_fin",   bif.o_fin, 1);
        drive_op(simple_op(6'd32, 32'h7000));
        bif.i_kill = 1'b1;
        @(negedge clk);
        bif.i_kill = 1'b0;
        bif.i_is_vld = 1'b0;
        chk("fl_fin",   bif.o_fin, 0);
        chk("fl_ready", bif.o_ready, 1);
        bif.i_wb_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fl_no_result", bif.o_fin, 0);
        end

        // Flush with an empty pipeline drops the issue even though o_ready=1.
        v = simple_op(6'd33, 32'h8000);
        drive_op(v);
        bif.i_kill = 1'b1;
        @(negedge clk);
        bif.i_kill = 1'b0;
        bif.i_is_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("fl2_no_result", bif.o_fin, 0);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_branch.md
Name: ex_branch

Overview:
- Branch execution unit; consumes the single-issue port of the branch reservation station.
- Receives the operation the station reads out on an issue grant and resolves JAL, JALR and conditional branches.
- Broadcasts the link value back to all reservation stations on the jal/jalr forwarding bus.
- Reports completion, actual direction, actual target and misprediction to the ROB / fetch redirect.
- Two-stage registered pipeline (E1 operand latch, E2 result latch) with a write-back acknowledge handshake and flush.

Parameters:
- DATA_W, 32, operand/result width
- PC_W, 32, program counter width
- TAG_W, 6, rename-buffer tag width
- OP_W, 4, alu_op_sel width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- o_ready  out  1  unit can accept an issue this cycle (to issue select)
- i_is_vld  in  1  issue valid
- i_is_jal  in  1  op is JAL
- i_is_jalr  in  1  op is JALR
- i_alu_op_sel  in  OP_W  compare code for conditional branch
- i_rs1_srcopr  in  DATA_W  source operand 1
- i_rs2_srcopr  in  DATA_W  source operand 2
- i_pc  in  PC_W  instruction PC
- i_imm  in  DATA_W  sign-extended immediate
- i_pred_jmpaddr  in  PC_W  predicted next PC
- i_rrftag  in  TAG_W  destination rename tag
- i_kill  in  1  flush: drop all in-flight ops
- i_wb_ack  in  1  ROB/broadcast accepted the E2 result
- o_fin  out  1  E2 result valid (any branch op)
- o_exfin_jal_jalr  out  1  o_fin && (jal || jalr)
- o_ex_jal_jalr_rrftag  out  TAG_W  tag of E2 op
- o_exfin_jal_jalr_res  out  DATA_W  link value pc+4
- o_br_taken  out  1  actual direction
- o_br_target  out  PC_W  actual next PC
- o_br_mispred  out  1  actual next PC != predicted

Behaviour:
- Reset (async, rst_n=0): e1_vld=0, e2_vld=0; all outputs 0 except o_ready=1. Data registers cleared to 0.
- Advance rule:
  - adv2 = e1_vld && (!e2_vld || i_wb_ack)
  - o_ready = !e1_vld || adv2 (combinational)
  - Issue accepted when i_is_vld && o_ready; fields latched into E1 at that edge.
  - i_is_vld with o_ready=0 is ignored; the issue select must not assert it then.
- Latency: issue accepted at edge N, E1 valid after N, o_fin high after N+1 when E2 is free. Throughput 1 op/cycle with continuous i_wb_ack.
- E2 hold: E2 contents and o_fin stay stable while !i_wb_ack. E2 clears on ack unless refilled by adv2 the same cycle.
- Compute (combinational on E1, registered into E2):
  - link = pc+4 (mod 2^PC_W, zero-extended to DATA_W)
  - JAL: taken=1, target = pc+imm
  - JALR: taken=1, target = (rs1+imm) with bit0 cleared
  - Conditional branch: compare codes 0 EQ, 1 NE, 2 LT signed, 3 GE signed, 4 LTU, 5 GEU; codes 6..15 give taken=0. target = taken ? pc+imm : pc+4.
  - JAL takes priority over JALR if both are set.
  - mispred = (target != pred_jmpaddr)
  - All adds wrap at width, no overflow flag.
- o_exfin_jal_jalr_res is meaningful only when o_exfin_jal_jalr=1; it is still driven with link otherwise.
- Flush (i_kill=1):
  - Next edge: e1_vld=0 and e2_vld=0.
  - Any issue in the same cycle is dropped, including one with o_ready=1.
  - Any i_wb_ack in that cycle is still honoured by the consumer; the unit drops E2 regardless.
- i_kill and rst_n both override any concurrent issue/advance.
- Simultaneous E2 ack + E1 advance + new issue in the same cycle is legal and lossless.

Test Plan:
- Reset then idle: o_ready=1, o_fin=0, all data outputs 0.
- JAL pc=0x100, imm=0x20, pred=0x120, ack held 1, issue at edge N: o_fin=1 after N+1; target=0x120, taken=1, mispred=0, o_exfin_jal_jalr=1, res=0x104.
- JALR rs1=0x2001, imm=0x4, pred=0x2000: target=0x2004, mispred=1, res=pc+4.
- BLT code 2, rs1=0xFFFFFFFF, rs2=1: taken=1. Same operands with BLTU code 4: taken=0, target=pc+4. Both ops: o_exfin_jal_jalr=0.
- Back-pressure: i_wb_ack=0, issue 3 back-to-back ops. Two ops are accepted, o_ready drops to 0, E2 outputs stay stable. Raise ack: results drain in order, o_ready returns to 1.
- Flush: E1 and E2 full, i_kill=1 with concurrent i_is_vld. Next cycle o_fin=0, o_ready=1, no later result appears for any of the three ops.
